// File: rtl/ha_array_reducer.sv
// Final-stage reducer for 8x8 approximate multipliers: captures four half-adder
// array bundles, weights and accumulates them over four cycles, emits a saturated product.
module ha_array_reducer #(
  parameter int ACC_W = 17,
  parameter int OUT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [6:0]       ha_array_0_b,
  input  logic [6:0]       ha_array_1_b,
  input  logic [6:0]       ha_array_2_b,
  input  logic [6:0]       ha_array_3_b,
  input  logic [8:0]       ha_array_0_t,
  input  logic [8:0]       ha_array_1_t,
  input  logic [8:0]       ha_array_2_t,
  input  logic [8:0]       ha_array_3_t,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] p,
  output logic             ovf,
  output logic [1:0]       dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid && ready; the
  // producer holds its data stable while valid is high and ready is low.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             r_state;
  logic [1:0]         r_idx;
  logic [ACC_W-1:0]   r_acc;
  logic [8:0]         r_t [4];
  logic [6:0]         r_b [4];
  logic               r_in_ready;
  logic               r_out_valid;
  logic [OUT_W-1:0]   r_p;
  logic               r_ovf;

  logic [8:0]         w_t;
  logic [6:0]         w_b;
  logic [ACC_W-1:0]   w_v;
  logic [ACC_W-1:0]   w_term;
  logic [ACC_W-1:0]   w_sum;
  logic               w_sat;

  // Carry rows sit two bit positions above the sum rows; array k is weighted by 4^k.
  always_comb begin
    w_t    = r_t[r_idx];
    w_b    = r_b[r_idx];
    w_v    = ACC_W'(w_t) + (ACC_W'(w_b) << 2);
    w_term = w_v << {r_idx, 1'b0};
    w_sum  = r_acc + w_term;
    w_sat  = |w_sum[ACC_W-1:OUT_W];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_idx       <= 2'd0;
      r_acc       <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_p         <= '0;
      r_ovf       <= 1'b0;
      for (int k = 0; k < 4; k++) begin
        r_t[k] <= '0;
        r_b[k] <= '0;
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid && r_in_ready) begin
            r_t[0]     <= ha_array_0_t;
            r_t[1]     <= ha_array_1_t;
            r_t[2]     <= ha_array_2_t;
            r_t[3]     <= ha_array_3_t;
            r_b[0]     <= ha_array_0_b;
            r_b[1]     <= ha_array_1_b;
            r_b[2]     <= ha_array_2_b;
            r_b[3]     <= ha_array_3_b;
            r_acc      <= '0;
            r_idx      <= 2'd0;
            r_in_ready <= 1'b0;
            r_state    <= S_ACC;
          end
        end
        S_ACC: begin
          r_acc <= w_sum;
          r_idx <= r_idx + 2'd1;
          if (r_idx == 2'd3) begin
            r_out_valid <= 1'b1;
            r_p         <= w_sat ? {OUT_W{1'b1}} : w_sum[OUT_W-1:0];
            r_ovf       <= w_sat;
            r_state     <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign p         = r_p;
  assign ovf       = r_ovf;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_ha_array_reducer.sv
// Self-checking bench for ha_array_reducer: directed scenarios plus a random
// end-to-end run, with a queue of expected {ovf, p} results.
module tb_ha_array_reducer;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [8:0]  t_in [4];
  logic [6:0]  b_in [4];
  logic        out_valid;
  logic        out_ready;
  logic [15:0] p;
  logic        ovf;
  logic [1:0]  dbg_state;

  int checks = 0;
  int errors = 0;
  logic [16:0] exp_q[$];

  ha_array_reducer #(.ACC_W(17), .OUT_W(16)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .ha_array_0_b(b_in[0]), .ha_array_1_b(b_in[1]),
    .ha_array_2_b(b_in[2]), .ha_array_3_b(b_in[3]),
    .ha_array_0_t(t_in[0]), .ha_array_1_t(t_in[1]),
    .ha_array_2_t(t_in[2]), .ha_array_3_t(t_in[3]),
    .out_valid(out_valid), .out_ready(out_ready),
    .p(p), .ovf(ovf), .dbg_state(dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [16:0] model();
    int s = 0;
    int w = 1;
    for (int k = 0; k < 4; k++) begin
      s = s + (int'(t_in[k]) + 4 * int'(b_in[k])) * w;
      w = w * 4;
    end
    if (s > 65535) return {1'b1, 16'hFFFF};
    return {1'b0, s[15:0]};
  endfunction

  task automatic clear_bundle();
    for (int k = 0; k < 4; k++) begin
      t_in[k] = '0;
      b_in[k] = '0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Driver: holds in_valid until a handshake edge, then queues the expectation.
  task automatic drive_bundle(input logic [16:0] exp, input bit do_push);
    bit ok;
    int n = 0;
    in_valid = 1'b1;
    forever begin
      ok = in_ready;
      tick();
      if (ok) break;
      n++;
      if (n > 200) begin
        errors++;
        $display("FAIL drive_timeout: in_ready stayed %0b, required 1", in_ready);
        break;
      end
    end
    checks++;
    in_valid = 1'b0;
    if (do_push) exp_q.push_back(exp);
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!out_valid && lat < 50) begin
      tick();
      lat++;
    end
  endtask

  task automatic receive(input string name);
    int lat;
    logic [16:0] exp;
    out_ready = 1'b1;
    wait_valid(lat);
    checks++;
    if (!out_valid) begin
      errors++;
      $display("FAIL %s_timeout: out_valid=%0b required 1", name, out_valid);
    end else if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s_queue: result {%0b,%0d} with empty expected queue", name, ovf, p);
    end else begin
      exp = exp_q.pop_front();
      if ({ovf, p} !== exp) begin
        errors++;
        $display("FAIL %s: got ovf=%0b p=%0d, expected ovf=%0b p=%0d", name, ovf, p, exp[16], exp[15:0]);
      end
    end
    tick();
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s_return_idle: out_valid=%0b in_ready=%0b, expected 0/1", name, out_valid, in_ready);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    clear_bundle();
    repeat (3) tick();
    rst = 1'b0;
    tick();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || p !== 16'd0 || ovf !== 1'b0 || dbg_state !== 2'd0) begin
      errors++;
      $display("FAIL reset_state: in_ready=%0b out_valid=%0b p=%0d ovf=%0b st=%0d, expected 1/0/0/0/0",
               in_ready, out_valid, p, ovf, dbg_state);
    end
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || dbg_state !== 2'd0) begin
        errors++;
        $display("FAIL idle_hold[%0d]: in_ready=%0b out_valid=%0b st=%0d, expected 1/0/0",
                 i, in_ready, out_valid, dbg_state);
      end
    end
  endtask

  task automatic test_single_bits();
    int lat;
    // array_0_t bit 0: also check handshake-to-out_valid latency
    clear_bundle();
    t_in[0] = 9'h001;
    drive_bundle({1'b0, 16'd1}, 1'b1);
    wait_valid(lat);
    checks++;
    if (lat != 4) begin
      errors++;
      $display("FAIL latency: out_valid after %0d edges, expected 4", lat);
    end
    receive("bit_a0t0");
    clear_bundle();
    b_in[3] = 7'h40;
    drive_bundle({1'b0, 16'd16384}, 1'b1);
    receive("bit_a3b6");
    clear_bundle();
    t_in[1] = 9'h100;
    drive_bundle({1'b0, 16'd1024}, 1'b1);
    receive("bit_a1t8");
  endtask

  task automatic test_saturation();
    for (int k = 0; k < 4; k++) begin
      t_in[k] = 9'h1FF;
      b_in[k] = 7'h7F;
    end
    drive_bundle({1'b1, 16'hFFFF}, 1'b1);
    receive("sat_all_ones");
    clear_bundle();
    t_in[3] = 9'h1FF;
    drive_bundle({1'b0, 16'd32704}, 1'b1);
    receive("a3t_full");
    // 3 + 4*3 + 16*19 + 64*1019 = 65535, then one more
    t_in[0] = 9'd3; t_in[1] = 9'd3; t_in[2] = 9'd19; t_in[3] = 9'h1FF; b_in[3] = 7'h7F;
    drive_bundle({1'b0, 16'hFFFF}, 1'b1);
    receive("edge_65535");
    t_in[0] = 9'd4;
    drive_bundle({1'b1, 16'hFFFF}, 1'b1);
    receive("edge_65536");
  endtask

  task automatic test_backpressure();
    int lat;
    logic [16:0] held;
    clear_bundle();
    t_in[0] = 9'd5; b_in[1] = 7'd2;
    drive_bundle({1'b0, 16'd37}, 1'b1);
    out_ready = 1'b0;
    wait_valid(lat);
    held = {ovf, p};
    t_in[0] = 9'd77;
    in_valid = 1'b1;
    for (int i = 0; i < 7; i++) begin
      tick();
      checks++;
      if ({ovf, p} !== held || out_valid !== 1'b1 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL backpressure[%0d]: ovf/p=%0h out_valid=%0b in_ready=%0b, expected %0h/1/0",
                 i, {ovf, p}, out_valid, in_ready, held);
      end
    end
    in_valid = 1'b0;
    receive("bp_result");
    clear_bundle();
    t_in[2] = 9'd1;
    drive_bundle({1'b0, 16'd16}, 1'b1);
    receive("bp_next");
  endtask

  task automatic test_reset_mid();
    bit seen = 0;
    clear_bundle();
    t_in[3] = 9'd9;
    drive_bundle(17'd0, 1'b0);
    tick();
    rst = 1'b1;
    #3;
    checks++;
    if (dbg_state !== 2'd0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_async: st=%0d in_ready=%0b, expected 0/1", dbg_state, in_ready);
    end
    tick();
    rst = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (out_valid) seen = 1;
      tick();
    end
    out_ready = 1'b0;
    checks++;
    if (seen || p !== 16'd0 || ovf !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid: seen_valid=%0b p=%0d ovf=%0b in_ready=%0b, expected 0/0/0/1",
               seen, p, ovf, in_ready);
    end
    clear_bundle();
    t_in[0] = 9'h003;
    drive_bundle({1'b0, 16'd3}, 1'b1);
    receive("after_reset");
  endtask

  task automatic test_random(input int n);
    fork
      begin
        for (int i = 0; i < n; i++) begin
          for (int k = 0; k < 4; k++) begin
            t_in[k] = 9'($urandom_range(0, 511));
            b_in[k] = 7'($urandom_range(0, 127));
          end
          if ($urandom_range(0, 7) == 0) begin
            for (int k = 0; k < 4; k++) begin
              t_in[k] = 9'h1FF;
              b_in[k] = 7'h7F;
            end
          end
          drive_bundle(model(), 1'b1);
        end
      end
      begin
        for (int i = 0; i < n; i++) begin
          bit ok;
          bit done = 0;
          int to = 0;
          logic [16:0] got;
          logic [16:0] exp;
          while (!done) begin
            out_ready = ($urandom_range(0, 3) != 0);
            ok  = out_valid && out_ready;
            got = {ovf, p};
            tick();
            if (ok) begin
              done = 1;
              checks++;
              if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL rand_queue[%0d]: result %0h with empty expected queue", i, got);
              end else begin
                exp = exp_q.pop_front();
                if (got !== exp) begin
                  errors++;
                  $display("FAIL rand[%0d]: got ovf=%0b p=%0d, expected ovf=%0b p=%0d",
                           i, got[16], got[15:0], exp[16], exp[15:0]);
                end
              end
            end else begin
              to++;
              if (to > 200) begin
                done = 1;
                checks++;
                errors++;
                $display("FAIL rand_timeout[%0d]: out_valid=%0b, expected a result", i, out_valid);
              end
            end
          end
        end
        out_ready = 1'b0;
      end
    join
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL rand_leftover: %0d expected results never produced, required 0", exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_single_bits();
    test_saturation();
    test_backpressure();
    test_reset_mid();
    test_random(2000);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
